// File: rtl/gcd_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gcd_controller
// Description : Control FSM for a 16-bit subtractive GCD datapath with
//               operand/result valid-ready handshakes and an iteration limit.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic             gt_i,
    input  logic             lt_i,
    input  logic             eq_i,
    output logic             ldA_o,
    output logic             ldB_o,
    output logic             sel1_o,
    output logic             sel2_o,
    output logic             sel_in_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] iter_count_o
);

    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_WAIT_B = 2'd1;
    localparam logic [1:0]       c_CALC   = 2'd2;
    localparam logic [1:0]       c_DONE   = 2'd3;
    localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_ITER);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            c_IDLE: begin
                if (op_valid_i) begin
                    state_d = c_WAIT_B;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            c_WAIT_B: begin
                if (op_valid_i) state_d = c_CALC;
            end
            c_CALC: begin
                // Limit check sits ahead of the increment so the counter never wraps.
                if (eq_i) begin
                    state_d = c_DONE;
                    err_d   = 1'b0;
                end else if (cnt_q == c_MAX) begin
                    state_d = c_DONE;
                    err_d   = 1'b1;
                end else if (gt_i || lt_i) begin
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = c_DONE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                if (res_ready_i) state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        op_ready_o  = 1'b0;
        ldA_o       = 1'b0;
        ldB_o       = 1'b0;
        sel1_o      = 1'b1;
        sel2_o      = 1'b0;
        sel_in_o    = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b0;
        // Reset masks the outputs combinationally so the run aborts in the reset cycle itself.
        if (!rst) begin
            busy_o = (state_q != c_IDLE);
            case (state_q)
                c_IDLE: begin
                    op_ready_o = 1'b1;
                    ldA_o      = op_valid_i;
                end
                c_WAIT_B: begin
                    op_ready_o = 1'b1;
                    ldB_o      = op_valid_i;
                end
                c_CALC: begin
                    if (!eq_i && (cnt_q != c_MAX)) begin
                        if (gt_i) begin
                            sel_in_o = 1'b1;
                            ldA_o    = 1'b1;
                        end else if (lt_i) begin
                            sel1_o   = 1'b0;
                            sel2_o   = 1'b1;
                            sel_in_o = 1'b1;
                            ldB_o    = 1'b1;
                        end
                    end
                end
                default: begin
                    res_valid_o = 1'b1;
                end
            endcase
        end
    end

    assign err_o        = err_q & ~rst;
    assign iter_count_o = rst ? '0 : cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gcd_controller
// Description : Randomised bench for gcd_controller with a datapath and a
//               plain-arithmetic Euclid reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_controller;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 8;

    logic        clk = 1'b0;
    logic        rst, op_valid, op_ready, gt, lt, eq;
    logic        ldA, ldB, sel1, sel2, sel_in, res_valid, res_ready, err, busy;
    logic [15:0] iter_count;
    logic [15:0] data_in;
    logic [15:0] dp_a = 16'd0;
    logic [15:0] dp_b = 16'd0;
    logic        kill;
    int          lda_cnt = 0;
    int          ldb_cnt = 0;
    int          n_chk   = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid_i   (op_valid),
        .op_ready_o   (op_ready),
        .gt_i         (gt),
        .lt_i         (lt),
        .eq_i         (eq),
        .ldA_o        (ldA),
        .ldB_o        (ldB),
        .sel1_o       (sel1),
        .sel2_o       (sel2),
        .sel_in_o     (sel_in),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .err_o        (err),
        .busy_o       (busy),
        .iter_count_o (iter_count)
    );

    // Datapath: two registers, a subtractor with muxed operands and a compare block.
    wire [15:0] w_x   = sel1 ? dp_a : dp_b;
    wire [15:0] w_y   = sel2 ? dp_a : dp_b;
    wire [15:0] w_bus = sel_in ? (w_x - w_y) : data_in;
    assign gt = !kill && (dp_a > dp_b);
    assign lt = !kill && (dp_a < dp_b);
    assign eq = !kill && (dp_a == dp_b);

    always @(posedge clk) begin
        if (ldA) begin dp_a <= w_bus; lda_cnt <= lda_cnt + 1; end
        if (ldB) begin dp_b <= w_bus; ldb_cnt <= ldb_cnt + 1; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Subtractive Euclid with the iteration cap; kl models a datapath with no flag set.
    task automatic model(input int a, input int b, input bit kl,
                         output int g, output int n, output int na, output int nb, output bit e);
        n = 0; na = 0; nb = 0;
        if (kl) begin
            e = 1'b1;
        end else begin
            while (a != b && n < MAX_ITER) begin
                if (a > b) begin a = a - b; na++; end
                else       begin b = b - a; nb++; end
                n++;
            end
            e = (a != b);
        end
        g = a;
    endtask

    task automatic do_run(input int a, input int b, input int gap_a, input int gap_b,
                          input int hold, input bit kl);
        int g, n, na, nb, la0, lb0, k;
        bit e;
        model(a, b, kl, g, n, na, nb, e);
        la0 = lda_cnt;
        lb0 = ldb_cnt;
        @(negedge clk);
        kill = kl;
        repeat (gap_a) @(negedge clk);
        op_valid = 1'b1; data_in = 16'(a);
        #1 chk("opA_ready", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (gap_b) @(negedge clk);
        op_valid = 1'b1; data_in = 16'(b);
        #1 chk("opB_ready", op_ready, 1);
        chk("busy_wait_b", busy, 1);
        @(posedge clk);
        #1 op_valid = 1'b0; data_in = 16'($urandom);
        k = 0;
        while (!res_valid && k < 64) begin
            @(posedge clk); #1; k++;
        end
        chk("latency", k, n + 1);
        chk("err", err, e);
        chk("iter_count", iter_count, n);
        chk("op_ready_done", op_ready, 0);
        chk("busy_done", busy, 1);
        if (!e) begin
            chk("result_a", dp_a, g);
            chk("result_b", dp_b, g);
        end
        chk("ldA_pulses", lda_cnt - la0, na + 1);
        chk("ldB_pulses", ldb_cnt - lb0, nb + 1);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk("hold_valid", res_valid, 1);
            chk("hold_no_ldA", lda_cnt - la0, na + 1);
            chk("hold_no_ldB", ldb_cnt - lb0, nb + 1);
            chk("hold_ready", op_ready, 0);
            if (!e) chk("hold_result", dp_a, g);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", res_valid, 0);
        chk("idle_ready", op_ready, 1);
        kill = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0; kill = 1'b0; data_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", op_ready, 1);

        do_run(48, 18, 0, 0, 0, 1'b0);
        do_run(7, 7, 0, 0, 0, 1'b0);
        do_run(5, 0, 0, 0, 0, 1'b0);
        do_run(21, 6, 0, 0, 10, 1'b0);
        do_run(35, 14, 3, 3, 0, 1'b0);
        do_run(0, 0, 0, 0, 0, 1'b0);
        do_run(0, 5, 1, 0, 2, 1'b0);
        do_run(12, 8, 0, 0, 0, 1'b1);

        // Abort a long run with reset while in CALC.
        @(negedge clk);
        op_valid = 1'b1; data_in = 16'd100;
        @(negedge clk);
        data_in = 16'd1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("calc_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_iter", iter_count, 0);
        chk("midrst_ldA", ldA, 0);
        chk("midrst_ready", op_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_busy", busy, 0);
        chk("after_rst_iter", iter_count, 0);
        chk("after_rst_ready", op_ready, 1);
        do_run(9, 6, 0, 0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            do_run(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
